// File: rtl/elevator_ctrl_if.sv
// rtl/elevator_ctrl_if.sv - call inputs and car status outputs of the elevator controller
interface elevator_ctrl_if;
  logic [3:0] req;
  logic [1:0] floor;
  logic [1:0] dir;
  logic       door_open;
  logic [3:0] pending;

  modport master (
    output req,
    input  floor, dir, door_open, pending
  );

  modport slave (
    input  req,
    output floor, dir, door_open, pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - 4-floor SCAN elevator scheduler with travel and door-dwell timers
module elevator_ctrl #(
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES   = 200_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  elevator_ctrl_if.slave bus
);
  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    floor_q, floor_d;
  logic [1:0]    dir_q, dir_d;
  logic          door_q, door_d;
  logic [3:0]    pending_q, pending_d;
  logic          up_q, up_d;
  logic [3:0]    calls, served;
  logic [1:0]    nf;
  logic          above, below, ahead_after;

  function automatic logic [3:0] above_of(input logic [1:0] f);
    case (f)
      2'd0:    above_of = 4'b1110;
      2'd1:    above_of = 4'b1100;
      2'd2:    above_of = 4'b1000;
      default: above_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] below_of(input logic [1:0] f);
    below_of = ~(above_of(f) | (4'b0001 << f));
  endfunction

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    door_d      = door_q;
    up_d        = up_q;
    served      = '0;
    nf          = floor_q;
    ahead_after = 1'b0;
    calls       = pending_q | bus.req;
    above       = |(calls & above_of(floor_q));
    below       = |(calls & below_of(floor_q));
    case (state_q)
      IDLE: begin
        dir_d   = 2'd3;
        door_d  = 1'b0;
        timer_d = '0;
        if (calls[floor_q]) begin
          state_d         = DOOR;
          door_d          = 1'b1;
          served[floor_q] = 1'b1;
        end else if (up_q ? above : below) begin
          state_d = up_q ? MOVE_UP : MOVE_DOWN;
          dir_d   = up_q ? 2'd1 : 2'd2;
        end else if (up_q ? below : above) begin
          state_d = up_q ? MOVE_DOWN : MOVE_UP;
          dir_d   = up_q ? 2'd2 : 2'd1;
          up_d    = ~up_q;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TRAVEL_LAST) begin
          nf          = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
          floor_d     = nf;
          timer_d     = '0;
          ahead_after = |(calls & ((state_q == MOVE_UP) ? above_of(nf) : below_of(nf)));
          if (calls[nf]) begin
            state_d    = DOOR;
            dir_d      = 2'd3;
            door_d     = 1'b1;
            served[nf] = 1'b1;
          end else if (!ahead_after) begin
            // Unreachable while calls clear only when served; keeps floor inside 0..3.
            state_d = IDLE;
            dir_d   = 2'd3;
          end
        end
      end
      DOOR: begin
        // A call at the open door only extends the dwell, it is never latched.
        served[floor_q] = 1'b1;
        timer_d         = timer_q + 1'b1;
        if (bus.req[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          state_d = IDLE;
          door_d  = 1'b0;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = calls & ~served;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      floor_q   <= 2'd0;
      dir_q     <= 2'd3;
      door_q    <= 1'b0;
      pending_q <= 4'b0000;
      up_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      pending_q <= pending_d;
      up_q      <= up_d;
    end
  end

  assign bus.floor     = floor_q;
  assign bus.dir       = dir_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pending_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - scoreboard bench for elevator_ctrl with short travel and dwell timers
module tb_elevator_ctrl;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  elevator_ctrl_if bus();

  elevator_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [8:0] want;
    string      name;
  } exp_t;

  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] snap();
    return {bus.floor, bus.dir, bus.door_open, bus.pending};
  endfunction

  function automatic exp_t ex(int c, logic [1:0] f, logic [1:0] d, logic o, logic [3:0] p, string nm);
    exp_t e;
    e.cyc  = c;
    e.want = {f, d, o, p};
    e.name = nm;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 4'b0000;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (bus.floor !== 2'd0) begin n_fail++; $display("FAIL reset_floor: got %0d want 0", bus.floor); end
    if (bus.dir !== 2'd3) begin n_fail++; $display("FAIL reset_dir: got %0d want 3", bus.dir); end
    if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL reset_door: got %b want 0", bus.door_open); end
    if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (snap() !== 9'b00_11_0_0000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 001100000", snap());
    end
  endtask

  task automatic test_door_here();
    int base;
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    base = cyc + 1;
    sbq.push_back(ex(base + 0, 2'd0, 2'd3, 1'b1, 4'b0000, "here_open"));
    sbq.push_back(ex(base + 2, 2'd0, 2'd3, 1'b1, 4'b0000, "here_still_open"));
    sbq.push_back(ex(base + 3, 2'd0, 2'd3, 1'b0, 4'b0000, "here_closed"));
    bus.req = 4'b0001;
    for (int n = 0; n < 20 && sbq.size() > 0; n++) begin
      @(negedge clk);
      bus.req = 4'b0000;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front(); got = snap(); n_checks++;
        if (got !== e.want) begin
          n_fail++;
          $display("FAIL %s: got f=%0d d=%0d door=%b p=%b want f=%0d d=%0d door=%b p=%b", e.name,
                   got[8:7], got[6:5], got[4], got[3:0], e.want[8:7], e.want[6:5], e.want[4], e.want[3:0]);
        end
      end
    end
    if (sbq.size() > 0) begin n_checks++; n_fail++; $display("FAIL here_timeout: got %0d pending checks want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_travel_up();
    int base;
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    base = cyc + 1;
    sbq.push_back(ex(base + 0,  2'd0, 2'd1, 1'b0, 4'b1000, "up_start"));
    sbq.push_back(ex(base + 3,  2'd0, 2'd1, 1'b0, 4'b1000, "up_before_f1"));
    sbq.push_back(ex(base + 4,  2'd1, 2'd1, 1'b0, 4'b1000, "up_f1"));
    sbq.push_back(ex(base + 8,  2'd2, 2'd1, 1'b0, 4'b1000, "up_f2"));
    sbq.push_back(ex(base + 12, 2'd3, 2'd3, 1'b1, 4'b0000, "up_f3_open"));
    sbq.push_back(ex(base + 14, 2'd3, 2'd3, 1'b1, 4'b0000, "up_f3_dwell"));
    sbq.push_back(ex(base + 15, 2'd3, 2'd3, 1'b0, 4'b0000, "up_f3_closed"));
    sbq.push_back(ex(base + 16, 2'd3, 2'd3, 1'b0, 4'b0000, "up_f3_idle"));
    bus.req = 4'b1000;
    for (int n = 0; n < 40 && sbq.size() > 0; n++) begin
      @(negedge clk);
      bus.req = 4'b0000;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front(); got = snap(); n_checks++;
        if (got !== e.want) begin
          n_fail++;
          $display("FAIL %s: got f=%0d d=%0d door=%b p=%b want f=%0d d=%0d door=%b p=%b", e.name,
                   got[8:7], got[6:5], got[4], got[3:0], e.want[8:7], e.want[6:5], e.want[4], e.want[3:0]);
        end
      end
    end
    if (sbq.size() > 0) begin n_checks++; n_fail++; $display("FAIL up_timeout: got %0d pending checks want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_dwell_restart();
    int base;
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    base = cyc + 1;
    sbq.push_back(ex(base + 0, 2'd3, 2'd3, 1'b1, 4'b0000, "dwell_open"));
    sbq.push_back(ex(base + 2, 2'd3, 2'd3, 1'b1, 4'b0000, "dwell_cycle2"));
    sbq.push_back(ex(base + 3, 2'd3, 2'd3, 1'b1, 4'b0000, "dwell_restarted"));
    sbq.push_back(ex(base + 5, 2'd3, 2'd3, 1'b1, 4'b0000, "dwell_extended"));
    sbq.push_back(ex(base + 6, 2'd3, 2'd3, 1'b0, 4'b0000, "dwell_closed"));
    bus.req = 4'b1000;
    for (int n = 0; n < 20 && sbq.size() > 0; n++) begin
      @(negedge clk);
      bus.req = 4'b0000;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front(); got = snap(); n_checks++;
        if (got !== e.want) begin
          n_fail++;
          $display("FAIL %s: got f=%0d d=%0d door=%b p=%b want f=%0d d=%0d door=%b p=%b", e.name,
                   got[8:7], got[6:5], got[4], got[3:0], e.want[8:7], e.want[6:5], e.want[4], e.want[3:0]);
        end
      end
      if (cyc == base + 2) bus.req = 4'b1000;
    end
    if (sbq.size() > 0) begin n_checks++; n_fail++; $display("FAIL dwell_timeout: got %0d pending checks want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    @(negedge clk);
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    n_checks++;
    if (snap() !== 9'b01_01_0_1000) begin
      n_fail++; $display("FAIL midmove_before: got %b want 010101000", snap());
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.floor !== 2'd0) begin n_fail++; $display("FAIL midmove_floor: got %0d want 0", bus.floor); end
    if (bus.dir !== 2'd3) begin n_fail++; $display("FAIL midmove_dir: got %0d want 3", bus.dir); end
    if (bus.door_open !== 1'b0) begin n_fail++; $display("FAIL midmove_door: got %b want 0", bus.door_open); end
    if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL midmove_pending: got %b want 0000", bus.pending); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (snap() !== 9'b00_11_0_0000) begin
      n_fail++; $display("FAIL midmove_no_resume: got %b want 001100000", snap());
    end
  endtask

  task automatic test_scan_continue();
    int base;
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    base = cyc + 1;
    sbq.push_back(ex(base + 5,  2'd1, 2'd1, 1'b0, 4'b1001, "scan_latched_behind"));
    sbq.push_back(ex(base + 8,  2'd2, 2'd1, 1'b0, 4'b1001, "scan_keeps_up"));
    sbq.push_back(ex(base + 12, 2'd3, 2'd3, 1'b1, 4'b0001, "scan_serve_f3"));
    sbq.push_back(ex(base + 15, 2'd3, 2'd3, 1'b0, 4'b0001, "scan_idle_f3"));
    sbq.push_back(ex(base + 16, 2'd3, 2'd2, 1'b0, 4'b0001, "scan_reverse"));
    sbq.push_back(ex(base + 20, 2'd2, 2'd2, 1'b0, 4'b0001, "scan_down_f2"));
    sbq.push_back(ex(base + 27, 2'd1, 2'd2, 1'b0, 4'b0001, "scan_before_f0"));
    sbq.push_back(ex(base + 28, 2'd0, 2'd3, 1'b1, 4'b0000, "scan_serve_f0"));
    sbq.push_back(ex(base + 31, 2'd0, 2'd3, 1'b0, 4'b0000, "scan_done"));
    bus.req = 4'b1000;
    for (int n = 0; n < 60 && sbq.size() > 0; n++) begin
      @(negedge clk);
      bus.req = 4'b0000;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front(); got = snap(); n_checks++;
        if (got !== e.want) begin
          n_fail++;
          $display("FAIL %s: got f=%0d d=%0d door=%b p=%b want f=%0d d=%0d door=%b p=%b", e.name,
                   got[8:7], got[6:5], got[4], got[3:0], e.want[8:7], e.want[6:5], e.want[4], e.want[3:0]);
        end
      end
      if (cyc == base + 4) bus.req = 4'b0001;
    end
    if (sbq.size() > 0) begin n_checks++; n_fail++; $display("FAIL scan_timeout: got %0d pending checks want 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_same_cycle_multi();
    int base;
    exp_t e;
    logic [8:0] got;
    do_reset();
    @(negedge clk);
    base = cyc + 1;
    sbq.push_back(ex(base + 4,  2'd1, 2'd3, 1'b1, 4'b0000, "multi_at_f1"));
    sbq.push_back(ex(base + 8,  2'd1, 2'd3, 1'b0, 4'b0000, "multi_idle_f1"));
    sbq.push_back(ex(base + 9,  2'd1, 2'd1, 1'b0, 4'b1001, "multi_both_latched"));
    sbq.push_back(ex(base + 13, 2'd2, 2'd1, 1'b0, 4'b1001, "multi_up_first"));
    sbq.push_back(ex(base + 17, 2'd3, 2'd3, 1'b1, 4'b0001, "multi_serve_f3"));
    sbq.push_back(ex(base + 21, 2'd3, 2'd2, 1'b0, 4'b0001, "multi_then_down"));
    sbq.push_back(ex(base + 29, 2'd1, 2'd2, 1'b0, 4'b0001, "multi_pass_f1"));
    sbq.push_back(ex(base + 33, 2'd0, 2'd3, 1'b1, 4'b0000, "multi_serve_f0"));
    bus.req = 4'b0010;
    for (int n = 0; n < 60 && sbq.size() > 0; n++) begin
      @(negedge clk);
      bus.req = 4'b0000;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front(); got = snap(); n_checks++;
        if (got !== e.want) begin
          n_fail++;
          $display("FAIL %s: got f=%0d d=%0d door=%b p=%b want f=%0d d=%0d door=%b p=%b", e.name,
                   got[8:7], got[6:5], got[4], got[3:0], e.want[8:7], e.want[6:5], e.want[4], e.want[3:0]);
        end
      end
      if (cyc == base + 8) bus.req = 4'b1001;
    end
    if (sbq.size() > 0) begin n_checks++; n_fail++; $display("FAIL multi_timeout: got %0d pending checks want 0", sbq.size()); sbq.delete(); end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    bus.req  = 4'b0000;
    test_reset();
    test_door_here();
    test_travel_up();
    test_dwell_restart();
    test_reset_mid_move();
    test_scan_continue();
    test_same_cycle_multi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
